// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and default
// frame geometry. Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;  // s_tick periods per bit
    localparam int UART_DATA_SIZE  = 8;   // data bits per frame, LSB first

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so an idle (high) line is seen while and right after reset is applied.
module uart_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Detects a start edge, re-checks it at mid-bit,
// samples each data bit at its centre (LSB first) and checks the stop bit.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
//
// Output protocol: there is no ready. rx_done, frame_error and parity_error
// are single-tick, mutually exclusive pulses; data is updated on the same edge
// that raises rx_done and is otherwise held until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_SIZE  = UART_DATA_SIZE
) (
    input  logic                 s_tick,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_SIZE-1:0] data,
    output logic                 rx_done,
    output logic                 frame_error
`ifdef UART_RX_PARITY_EN
    , output logic               parity_error
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

    uart_state_e          state;
    uart_state_e          next_state;
    logic                 rx_s;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_SIZE-1:0] shift_q;
    // Set after a low stop bit so a held-low (break) line cannot restart a frame.
    logic                 wait_high;
    logic                 sample_bit;
    logic                 stop_sample;
    logic                 done_set;
    logic                 ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 perr_set;
`endif

    uart_sync u_sync (
        .clk     (s_tick),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State register.
    always_ff @(posedge s_tick) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next-state decisions, all on the synchronized line.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!rx_s && !wait_high) next_state = ST_START;
            ST_START: if (tick_cnt == CNT_HALF) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick_cnt == CNT_LAST && bit_cnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                          next_state = ST_PARITY;
            ST_PARITY: if (tick_cnt == CNT_LAST) next_state = ST_STOP;
`else
                          next_state = ST_STOP;
`endif
            ST_STOP:  if (tick_cnt == CNT_LAST) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Sample strobes and result decode; the pulses are registered below.
    always_comb begin
        sample_bit  = (state == ST_DATA) && (tick_cnt == CNT_LAST);
        stop_sample = (state == ST_STOP) && (tick_cnt == CNT_LAST);
        ferr_set    = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
        // Even parity: data bits plus parity bit must hold an even number of ones.
        perr_set    = stop_sample && rx_s && (^{shift_q, par_bit});
        done_set    = stop_sample && rx_s && !(^{shift_q, par_bit});
`else
        done_set    = stop_sample && rx_s;
`endif
    end

    // Tick/bit counters, shift register, output word and result pulses.
    always_ff @(posedge s_tick) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            data        <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
            wait_high   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            // Every non-idle state ends its interval by clearing the counter.
            if (state == ST_IDLE || tick_cnt == CNT_LAST ||
                (state == ST_START && tick_cnt == CNT_HALF))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (state != ST_DATA) bit_cnt <= '0;
            else if (sample_bit)  bit_cnt <= bit_cnt + 1'b1;

            if (sample_bit) shift_q <= {rx_s, shift_q[DATA_SIZE-1:1]};

            if (done_set) data <= shift_q;

            if (ferr_set)                      wait_high <= 1'b1;
            else if (state == ST_IDLE && rx_s) wait_high <= 1'b0;

            rx_done     <= done_set;
            frame_error <= ferr_set;
`ifdef UART_RX_PARITY_EN
            if (state == ST_PARITY && tick_cnt == CNT_LAST) par_bit <= rx_s;
            parity_error <= perr_set;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, start glitch, bad stop bit,
// back-to-back frames, mid-frame reset, line break and (with
// UART_RX_PARITY_EN) parity checking.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DS = 8;
    // Start bit driven before tick edge E0; rx_s is low at T = E0+2 after the
    // synchronizer; stop sampled at T+152, pulse visible until edge T+153.
`ifdef UART_RX_PARITY_EN
    localparam int DONE_LAT = 3 + 152 + 16;
`else
    localparam int DONE_LAT = 3 + 152;
`endif

    logic          s_tick = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic [DS-1:0] data;
    logic          rx_done;
    logic          frame_error;
`ifdef UART_RX_PARITY_EN
    logic          parity_error;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int tick_n = 0;
    int start_tick = 0;
    int last_done_tick = 0;
    int n_done = 0;
    int n_ferr = 0;
    int n_perr = 0;
    logic [DS-1:0] exp_q[$];

    uart_rx dut (
        .s_tick      (s_tick),
        .reset_n     (reset_n),
        .rx          (rx),
        .data        (data),
        .rx_done     (rx_done),
        .frame_error (frame_error)
`ifdef UART_RX_PARITY_EN
        , .parity_error (parity_error)
`endif
    );

    // Clock and tick index.
    always #5 s_tick = ~s_tick;
    always @(posedge s_tick) tick_n++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / pulse monitor, sampled on the falling edge.
    logic          prev_done = 1'b0;
    logic          prev_ferr = 1'b0;
    logic          prev_rst = 1'b0;
    logic [DS-1:0] prev_data = '0;
    always @(negedge s_tick) begin
        logic perr_now;
        perr_now = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_now = parity_error;
        if (parity_error) n_perr++;
`endif
        if (rx_done) begin
            n_done++;
            last_done_tick = tick_n;
            check("exp_q_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx_data", data, exp_q.pop_front());
            check("done_width", prev_done, 0);
            check("done_excl", {frame_error, perr_now}, 0);
        end
        if (frame_error) begin
            n_ferr++;
            check("ferr_width", prev_ferr, 0);
            check("ferr_excl", perr_now, 0);
        end
        if (reset_n && prev_rst && !rx_done) check("data_hold", data, prev_data);
        prev_done = rx_done;
        prev_ferr = frame_error;
        prev_rst  = reset_n;
        prev_data = data;
    end

    // Drivers: rx changes on falling edges only.
    task automatic wait_ticks(input int n);
        repeat (n) @(negedge s_tick);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DS-1:0] b, input logic stop, input logic par_flip);
        start_tick = tick_n;
        send_bit(1'b0);
        for (int i = 0; i < DS; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        int d0, f0, p0;
        logic [DS-1:0] v;

        // Reset state.
        @(negedge s_tick);
        reset_n = 1'b0;
        wait_ticks(4);
        check("rst_data", data, 0);
        check("rst_done", rx_done, 0);
        check("rst_ferr", frame_error, 0);
        reset_n = 1'b1;
        wait_ticks(4);

        // Good frame 0xA5, with latency.
        d0 = n_done; f0 = n_ferr; p0 = n_perr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(8);
        check("a5_done_cnt", n_done - d0, 1);
        check("a5_data", data, 8'hA5);
        check("a5_latency", last_done_tick - start_tick, DONE_LAT);
        check("a5_no_err", (n_ferr - f0) + (n_perr - p0), 0);

        // 4-tick glitch on idle line.
        d0 = n_done; f0 = n_ferr;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(40);
        check("glitch_no_pulse", (n_done - d0) + (n_ferr - f0), 0);
        check("glitch_data", data, 8'hA5);

        // 0x3C with stop bit low.
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(8);
        check("ferr_cnt", n_ferr - f0, 1);
        check("ferr_no_done", n_done - d0, 0);
        check("ferr_data", data, 8'hA5);

        // Back-to-back 0x00 then 0xFF.
        d0 = n_done; f0 = n_ferr;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(8);
        check("b2b_done_cnt", n_done - d0, 2);
        check("b2b_data", data, 8'hFF);
        check("b2b_no_ferr", n_ferr - f0, 0);

        // Reset during bit 4 of 0x55, held until the frame has passed.
        d0 = n_done; f0 = n_ferr;
        v = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < DS; i++) begin
            if (i == 4) begin
                rx = v[i];
                wait_ticks(8);
                reset_n = 1'b0;
                wait_ticks(8);
            end else begin
                send_bit(v[i]);
            end
        end
`ifdef UART_RX_PARITY_EN
        send_bit(^v);
`endif
        send_bit(1'b1);
        wait_ticks(4);
        reset_n = 1'b1;
        wait_ticks(4);
        check("abort_no_pulse", (n_done - d0) + (n_ferr - f0), 0);
        check("abort_data_rst", data, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(8);
        check("after_rst_done", n_done - d0, 1);
        check("after_rst_data", data, 8'h81);

        // Line break: one frame_error, then no restart until the line rises.
        d0 = n_done; f0 = n_ferr;
        rx = 1'b0;
        wait_ticks(420);
        check("break_ferr_cnt", n_ferr - f0, 1);
        check("break_no_done", n_done - d0, 0);
        check("break_data", data, 8'h81);
        rx = 1'b1;
        wait_ticks(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(8);
        check("post_break_done", n_done - d0, 1);
        check("post_break_data", data, 8'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07: parity bit 0 is wrong, parity bit 1 is right.
        d0 = n_done; f0 = n_ferr; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(8);
        check("par_bad_perr", n_perr - p0, 1);
        check("par_bad_no_done", n_done - d0, 0);
        check("par_bad_data", data, 8'h5A);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_ticks(8);
        check("par_ok_done", n_done - d0, 1);
        check("par_ok_data", data, 8'h07);
        check("par_ok_no_err", (n_perr - p0 - 1) + (n_ferr - f0), 0);
`endif

        // Final report.
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
